fifo_rr_arbiter: RTL and testbench

FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

---
 rtl/fifo_rr_arbiter_pkg.sv | 14 +
 rtl/fifo_rr_arbiter_rr_pick4.sv | 38 +++
 rtl/fifo_rr_arbiter.sv | 101 ++++++++++
 tb/tb_fifo_rr_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_arbiter_pkg.sv
// fifo_rr_arbiter_pkg
// Shared constants for the round-robin FIFO merge arbiter.
//   DATA_SIZE_DEF : default token width, MSB is the tag bit carried through
//   NUM_CH        : number of upstream channels (the picker is built for 4)
//   CNT_W         : width of the delivered-token counter
//   LAST_GRANT_RST: lastGrant reset value, chosen so channel 0 is scanned first
package fifo_rr_arbiter_pkg;

   localparam int DATA_SIZE_DEF = 8;
   localparam int NUM_CH = 4;
   localparam int CNT_W = 16;
   localparam logic [1:0] LAST_GRANT_RST = 2'd3;

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick4.sv
// rr_pick4
// Purely combinational rotating-priority picker for four requesters.
// The scan starts at the channel after lastGrant and wraps modulo 4, so the
// most recently served channel has the lowest priority.
//   req       : request vector, bit i = channel i wants service
//   lastGrant : index of the channel served most recently
//   grant     : one-hot grant (all zero when nothing requests)
//   grantIdx  : binary index of the granted channel (0 when nothing requests)
//   anyValid  : at least one request present
module rr_pick4 (
   input  logic [3:0] req,
   input  logic [1:0] lastGrant,
   output logic [3:0] grant,
   output logic [1:0] grantIdx,
   output logic       anyValid
);

   // Walk the four positions after lastGrant in order; the first requester
   // found wins and later positions are ignored.
   always_comb begin
      logic [1:0] idx;
      logic found;
      grant = 4'b0000;
      grantIdx = 2'd0;
      found = 1'b0;
      idx = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         idx = lastGrant + 2'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            grant[idx] = 1'b1;
            grantIdx = idx;
         end
      end
      anyValid = found;
   end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter
// Merges NUM_CH upstream FIFOs into one downstream FIFO using round-robin
// arbitration. A single holding register sits between the upstream heads and
// the downstream write port; it can drain and refill on the same edge so a
// continuous stream moves at one token per cycle.
//   clk, rst   : clock and asynchronous active-high reset
//   inData     : upstream head tokens, channel i at [i*DATA_SIZE +: DATA_SIZE]
//   inEmpty    : upstream empty flags
//   inRead     : upstream read strobes, at most one high, combinational
//   chanEnable : per-channel arbitration mask
//   outData    : token in the holding register
//   outWrite   : downstream write strobe (holding register valid)
//   outFull    : downstream full flag
//   grantIdx   : channel the held token came from
//   tokenCount : tokens accepted downstream since reset, wraps at 16 bits
module fifo_rr_arbiter
   import fifo_rr_arbiter_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int NUM_CH = fifo_rr_arbiter_pkg::NUM_CH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH*DATA_SIZE-1:0] inData,
   input  logic [NUM_CH-1:0]         inEmpty,
   output logic [NUM_CH-1:0]         inRead,
   input  logic [NUM_CH-1:0]         chanEnable,
   output logic [DATA_SIZE-1:0]      outData,
   output logic                      outWrite,
   input  logic                      outFull,
   output logic [1:0]                grantIdx,
   output logic [CNT_W-1:0]          tokenCount
);

   logic             outValid;
   logic [1:0]       lastGrant;
   logic [3:0]       eligible;
   logic [3:0]       pickGrant;
   logic [1:0]       pickIdx;
   logic             pickAny;
   logic             holdFree;
   logic             doLoad;
   logic [DATA_SIZE-1:0] pickData;

   // A channel competes only when it has data and is enabled this very cycle,
   // so dropping chanEnable blocks a read combinationally.
   assign eligible = ~inEmpty & chanEnable;

   rr_pick4 picker (
      .req(eligible),
      .lastGrant(lastGrant),
      .grant(pickGrant),
      .grantIdx(pickIdx),
      .anyValid(pickAny)
   );

   // The holding register can accept a new token when empty, or when its
   // current token is being taken downstream on this edge.
   assign holdFree = ~outValid | ~outFull;
   assign doLoad = ~rst & holdFree & pickAny;
   assign inRead = doLoad ? pickGrant : 4'b0000;
   assign outWrite = outValid;

   // Select the winning channel's head token for the holding register.
   always_comb begin
      pickData = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pickIdx == 2'(i)) begin
            pickData = inData[i*DATA_SIZE +: DATA_SIZE];
         end
      end
   end

   // Holding register, round-robin pointer and delivery counter. A token counts
   // as delivered on any edge where it is presented and downstream has room,
   // independently of whether a new token replaces it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outValid <= 1'b0;
         outData <= '0;
         grantIdx <= 2'd0;
         lastGrant <= LAST_GRANT_RST;
         tokenCount <= '0;
      end else begin
         if (outValid && !outFull) begin
            tokenCount <= tokenCount + 16'd1;
         end
         if (holdFree) begin
            if (pickAny) begin
               outValid <= 1'b1;
               outData <= pickData;
               grantIdx <= pickIdx;
               lastGrant <= pickIdx;
            end else begin
               outValid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter
// Directed bench for fifo_rr_arbiter. Four small upstream FIFO models feed the
// arbiter; each is a 16-entry ring with a push counter (written by the
// stimulus) and a pop counter (advanced by the DUT's read strobes).
module tb_fifo_rr_arbiter;

   logic        clk;
   logic        rst;
   logic [31:0] inData;
   logic [3:0]  inEmpty;
   logic [3:0]  inRead;
   logic [3:0]  chanEnable;
   logic [7:0]  outData;
   logic        outWrite;
   logic        outFull;
   logic [1:0]  grantIdx;
   logic [15:0] tokenCount;

   logic [7:0]  chanMem [4][16];
   logic [31:0] pushCnt [4];
   logic [31:0] popCnt [4];
   logic        flushQ;

   int totalChecks;
   int badChecks;

   fifo_rr_arbiter dut (
      .clk(clk),
      .rst(rst),
      .inData(inData),
      .inEmpty(inEmpty),
      .inRead(inRead),
      .chanEnable(chanEnable),
      .outData(outData),
      .outWrite(outWrite),
      .outFull(outFull),
      .grantIdx(grantIdx),
      .tokenCount(tokenCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream heads and empty flags follow the ring counters.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         inEmpty[i] = (pushCnt[i] == popCnt[i]);
         inData[i*8 +: 8] = chanMem[i][popCnt[i][3:0]];
      end
   end

   // Pop on read strobes; a flush discards everything still queued.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (flushQ) popCnt[i] <= pushCnt[i];
         else if (inRead[i]) popCnt[i] <= popCnt[i] + 32'd1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic pushToken(input int ch, input logic [7:0] d);
      chanMem[ch][pushCnt[ch][3:0]] = d;
      pushCnt[ch] = pushCnt[ch] + 32'd1;
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] en, input logic full);
      chanEnable = en;
      outFull = full;
      #1;
   endtask

   task automatic flushAll();
      chanEnable = 4'b0000;
      flushQ = 1'b1;
      stepClock();
      flushQ = 1'b0;
   endtask

   initial begin
      totalChecks = 0;
      badChecks = 0;
      flushQ = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pushCnt[i] = 32'd0;
         popCnt[i] = 32'd0;
         for (int j = 0; j < 16; j++) chanMem[i][j] = 8'h00;
      end
      rst = 1'b1;
      chanEnable = 4'b0000;
      outFull = 1'b0;
      stepClock();
      stepClock();

      // Reset state, with eligible channels present to prove reads are blocked.
      for (int i = 0; i < 4; i++) begin
         pushToken(i, 8'((i << 4) | 1));
         pushToken(i, 8'((i << 4) | 2));
      end
      applyStimulus(4'b1111, 1'b0);
      checkOutput("rst_outWrite", 32'(outWrite), 32'd0);
      checkOutput("rst_outData", 32'(outData), 32'h00);
      checkOutput("rst_grantIdx", 32'(grantIdx), 32'd0);
      checkOutput("rst_tokenCount", 32'(tokenCount), 32'd0);
      checkOutput("rst_inRead", 32'(inRead), 32'd0);

      // All four channels busy: grants 0,1,2,3,0 one per cycle.
      rst = 1'b0;
      #1;
      checkOutput("rr_firstRead", 32'(inRead), 32'b0001);
      stepClock();
      checkOutput("rr_g0", 32'(grantIdx), 32'd0);
      checkOutput("rr_d0", 32'(outData), 32'h01);
      checkOutput("rr_w0", 32'(outWrite), 32'd1);
      stepClock();
      checkOutput("rr_g1", 32'(grantIdx), 32'd1);
      checkOutput("rr_d1", 32'(outData), 32'h11);
      stepClock();
      checkOutput("rr_g2", 32'(grantIdx), 32'd2);
      checkOutput("rr_d2", 32'(outData), 32'h21);
      stepClock();
      checkOutput("rr_g3", 32'(grantIdx), 32'd3);
      checkOutput("rr_d3", 32'(outData), 32'h31);
      checkOutput("rr_cnt3", 32'(tokenCount), 32'd3);
      stepClock();
      checkOutput("rr_g4", 32'(grantIdx), 32'd0);
      checkOutput("rr_d4", 32'(outData), 32'h02);
      applyStimulus(4'b0000, 1'b0);
      stepClock();
      checkOutput("rr_cnt5", 32'(tokenCount), 32'd5);
      checkOutput("rr_idle", 32'(outWrite), 32'd0);
      flushAll();

      // Single channel 2 stream: 11,22,33 back to back then idle.
      pushToken(2, 8'h11);
      pushToken(2, 8'h22);
      pushToken(2, 8'h33);
      applyStimulus(4'b1111, 1'b0);
      checkOutput("ch2_read", 32'(inRead), 32'b0100);
      stepClock();
      checkOutput("ch2_d0", 32'(outData), 32'h11);
      checkOutput("ch2_g0", 32'(grantIdx), 32'd2);
      stepClock();
      checkOutput("ch2_d1", 32'(outData), 32'h22);
      checkOutput("ch2_w1", 32'(outWrite), 32'd1);
      stepClock();
      checkOutput("ch2_d2", 32'(outData), 32'h33);
      stepClock();
      checkOutput("ch2_end", 32'(outWrite), 32'd0);
      checkOutput("ch2_cnt", 32'(tokenCount), 32'd8);

      // Backpressure: A5 held four cycles, then B6 follows with no bubble.
      pushToken(0, 8'hA5);
      pushToken(0, 8'hB6);
      applyStimulus(4'b1111, 1'b1);
      stepClock();
      for (int k = 0; k < 4; k++) begin
         checkOutput("bp_data", 32'(outData), 32'hA5);
         checkOutput("bp_write", 32'(outWrite), 32'd1);
         checkOutput("bp_read", 32'(inRead), 32'd0);
         stepClock();
      end
      checkOutput("bp_cntHeld", 32'(tokenCount), 32'd8);
      applyStimulus(4'b1111, 1'b0);
      checkOutput("bp_refill", 32'(inRead), 32'b0001);
      stepClock();
      checkOutput("bp_next", 32'(outData), 32'hB6);
      checkOutput("bp_nextW", 32'(outWrite), 32'd1);
      stepClock();
      checkOutput("bp_cnt", 32'(tokenCount), 32'd10);
      flushAll();

      // Mask 1010: grants alternate 1,3 and channels 0,2 are never read.
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 3; j++) pushToken(i, 8'((i << 4) | (j + 4)));
      end
      applyStimulus(4'b1010, 1'b0);
      checkOutput("mask_read0", 32'(inRead & 4'b0101), 32'd0);
      for (int k = 0; k < 4; k++) begin
         stepClock();
         checkOutput("mask_grant", 32'(grantIdx), (k % 2 == 0) ? 32'd1 : 32'd3);
         checkOutput("mask_read", 32'(inRead & 4'b0101), 32'd0);
      end
      applyStimulus(4'b0000, 1'b0);
      checkOutput("mask_dropRead", 32'(inRead), 32'd0);
      stepClock();
      checkOutput("mask_cnt", 32'(tokenCount), 32'd14);
      flushAll();

      // Reset while holding 7E clears it at once; channel 0 wins afterwards.
      pushToken(2, 8'h7E);
      applyStimulus(4'b1111, 1'b0);
      stepClock();
      checkOutput("mid_held", 32'(outData), 32'h7E);
      rst = 1'b1;
      pushToken(0, 8'h55);
      pushToken(3, 8'h44);
      #1;
      checkOutput("mid_write", 32'(outWrite), 32'd0);
      checkOutput("mid_data", 32'(outData), 32'h00);
      checkOutput("mid_cnt", 32'(tokenCount), 32'd0);
      checkOutput("mid_read", 32'(inRead), 32'd0);
      stepClock();
      checkOutput("mid_readHeld", 32'(inRead), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("mid_relRead", 32'(inRead), 32'b0001);
      stepClock();
      checkOutput("mid_g0", 32'(grantIdx), 32'd0);
      checkOutput("mid_d0", 32'(outData), 32'h55);
      stepClock();
      checkOutput("mid_g1", 32'(grantIdx), 32'd3);
      checkOutput("mid_d1", 32'(outData), 32'h44);
      flushAll();

      // 65537 deliveries wrap the counter to 1.
      rst = 1'b1;
      stepClock();
      pushCnt[0] = pushCnt[0] + 32'd70000;
      applyStimulus(4'b0001, 1'b0);
      rst = 1'b0;
      #1;
      repeat (65536) stepClock();
      checkOutput("wrap_ffff", 32'(tokenCount), 32'hFFFF);
      stepClock();
      checkOutput("wrap_zero", 32'(tokenCount), 32'd0);
      stepClock();
      checkOutput("wrap_one", 32'(tokenCount), 32'd1);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
